// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and helpers for the systolic skew feeder.
// Imported by the feeder top level.
package systolic_skew_feeder_pkg;

    typedef enum logic [1:0] {
        FEED_IDLE   = 2'd0,
        FEED_STREAM = 2'd1,
        FEED_DRAIN  = 2'd2,
        FEED_DONE   = 2'd3
    } feed_state_e;

    // The last wavefront reaches PE(ROWS-1,COLS-1) ROWS+COLS-1 cycles after it is accepted.
    // The drain counter therefore stops one short of that count.
    function automatic int unsigned drain_last(input int unsigned rows, input int unsigned cols);
        return rows + cols - 2;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// Fixed-depth registered delay line used to skew one operand lane.
// The output is always the oldest stage, so latency equals DEPTH cycles.
module skew_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for an output-stationary systolic array: sequences a K-wavefront job
// and applies the triangular row/column skew onto the array edge buses.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WORD_SIZE = 16,
    parameter int KW        = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*WORD_SIZE-1:0] a_vec,
    input  logic [COLS*WORD_SIZE-1:0] b_vec,
    output logic [ROWS*WORD_SIZE-1:0] left_in_bus,
    output logic [COLS*WORD_SIZE-1:0] top_in_bus,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned   DW         = $clog2(ROWS + COLS);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(drain_last(ROWS, COLS));
    localparam logic [KW-1:0] K_ONE      = KW'(1);

    feed_state_e   state, next_state;
    logic [KW-1:0] k_len_q;
    logic [KW-1:0] k_cnt;
    logic [DW-1:0] drain_cnt;
    logic          accept;
    logic          last_accept;

    logic [ROWS*WORD_SIZE-1:0] a_feed;
    logic [COLS*WORD_SIZE-1:0] b_feed;

    assign in_ready    = (state == FEED_STREAM);
    assign busy        = (state == FEED_STREAM) || (state == FEED_DRAIN);
    assign done        = (state == FEED_DONE);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (k_cnt == k_len_q - K_ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FEED_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            FEED_IDLE: begin
                if (start) begin
                    next_state = (k_len == '0) ? FEED_DONE : FEED_STREAM;
                end
            end
            FEED_STREAM: begin
                if (last_accept) begin
                    next_state = FEED_DRAIN;
                end
            end
            FEED_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    next_state = FEED_DONE;
                end
            end
            FEED_DONE: begin
                next_state = FEED_IDLE;
            end
            default: begin
                next_state = FEED_IDLE;
            end
        endcase
    end

    // Job length is captured only on an accepted start so later start pulses cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_len_q <= '0;
            k_cnt   <= '0;
        end else if (state == FEED_IDLE && start) begin
            k_len_q <= k_len;
            k_cnt   <= '0;
        end else if (accept) begin
            k_cnt <= k_cnt + K_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt <= '0;
        end else if (state == FEED_STREAM) begin
            drain_cnt <= '0;
        end else if (state == FEED_DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
        end
    end

    // Bubbles zero both operands together, so the MAC array simply accumulates 0.
    assign a_feed = accept ? a_vec : '0;
    assign b_feed = accept ? b_vec : '0;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_delay_line #(
            .DEPTH(r + 1),
            .WIDTH(WORD_SIZE)
        ) u_line (
            .clk (clk),
            .rst (rst),
            .din (a_feed[(r+1)*WORD_SIZE-1 -: WORD_SIZE]),
            .dout(left_in_bus[(r+1)*WORD_SIZE-1 -: WORD_SIZE])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        skew_delay_line #(
            .DEPTH(c + 1),
            .WIDTH(WORD_SIZE)
        ) u_line (
            .clk (clk),
            .rst (rst),
            .din (b_feed[(c+1)*WORD_SIZE-1 -: WORD_SIZE]),
            .dout(top_in_bus[(c+1)*WORD_SIZE-1 -: WORD_SIZE])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: cycle-level reference built from job timing rules
// and an injection history, plus a behavioural PE array product check.
module tb_systolic_skew_feeder;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int WS   = 16;
    localparam int KW   = 8;
    localparam int AW   = ROWS * WS;
    localparam int BW   = COLS * WS;
    localparam int MAXC = 2048;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] a_vec = '0;
    logic [BW-1:0] b_vec = '0;
    logic          in_ready, busy, done;
    logic [AW-1:0] left_in_bus;
    logic [BW-1:0] top_in_bus;

    systolic_skew_feeder #(
        .ROWS(ROWS),
        .COLS(COLS),
        .WORD_SIZE(WS),
        .KW(KW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .k_len(k_len),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_vec(a_vec),
        .b_vec(b_vec),
        .left_in_bus(left_in_bus),
        .top_in_bus(top_in_bus),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int clear_cyc = 0;

    logic [AW-1:0] inj_a [MAXC];
    logic [BW-1:0] inj_b [MAXC];
    logic [AW-1:0] obs_l [MAXC];
    logic [BW-1:0] obs_t [MAXC];

    // Job model: a job is open from the cycle after start until its done cycle.
    bit in_job     = 1'b0;
    int remaining  = 0;
    int ready_from = 0;
    int busy_until = 0;
    int done_at    = -1;

    function automatic bit exp_ready();
        return in_job && (cyc >= ready_from) && (remaining > 0);
    endfunction

    function automatic bit exp_busy();
        return in_job && (cyc >= ready_from) && (cyc <= busy_until);
    endfunction

    function automatic logic [AW-1:0] exp_left();
        logic [AW-1:0] v;
        logic [AW-1:0] src;
        int m;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            m = cyc - r - 1;
            if (m >= 0 && m >= clear_cyc) begin
                src = inj_a[m];
                v[r*WS +: WS] = src[r*WS +: WS];
            end
        end
        return v;
    endfunction

    function automatic logic [BW-1:0] exp_top();
        logic [BW-1:0] v;
        logic [BW-1:0] src;
        int m;
        v = '0;
        for (int c = 0; c < COLS; c++) begin
            m = cyc - c - 1;
            if (m >= 0 && m >= clear_cyc) begin
                src = inj_b[m];
                v[c*WS +: WS] = src[c*WS +: WS];
            end
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_update();
        bit acc;
        bit blocked;
        if (!rst) begin
            inj_a[cyc] = '0;
            inj_b[cyc] = '0;
            return;
        end
        acc = in_valid && exp_ready();
        inj_a[cyc] = acc ? a_vec : '0;
        inj_b[cyc] = acc ? b_vec : '0;
        if (acc) begin
            remaining--;
            if (remaining == 0) begin
                done_at    = cyc + ROWS + COLS;
                busy_until = done_at - 1;
            end
        end
        blocked = in_job || (done_at >= cyc);
        if (cyc == done_at) in_job = 1'b0;
        if (start && !blocked) begin
            if (k_len == '0) begin
                done_at = cyc + 1;
            end else begin
                in_job     = 1'b1;
                remaining  = int'(k_len);
                ready_from = cyc + 1;
                busy_until = MAXC;
            end
        end
    endtask

    task automatic tick();
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget cyc=%0d observed=overrun expected=<%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        check("in_ready", 64'(in_ready), 64'(exp_ready()));
        check("busy", 64'(busy), 64'(exp_busy()));
        check("done", 64'(done), 64'(rst && (cyc == done_at)));
        check("left_in_bus", 64'(left_in_bus), 64'(exp_left()));
        check("top_in_bus", 64'(top_in_bus), 64'(exp_top()));
        obs_l[cyc] = left_in_bus;
        obs_t[cyc] = top_in_bus;
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_ops();
        a_vec = {$urandom, $urandom};
        b_vec = {$urandom, $urandom};
    endtask

    task automatic run_job(input int k, input int pct);
        start = 1'b1;
        k_len = KW'(k);
        tick();
        start = 1'b0;
        for (int i = 0; i < 300 && (in_job || done_at >= cyc); i++) begin
            in_valid = ($urandom_range(99) < pct);
            rand_ops();
            tick();
        end
        check("job_finished", 64'(in_job || done_at >= cyc), 64'd0);
        in_valid = 1'b0;
        repeat (ROWS + COLS) tick();
    endtask

    initial begin
        int s;
        int sum;
        int golden;
        logic [AW-1:0] lv;
        logic [BW-1:0] tv;

        // Reset with random inputs, then idle with in_valid held high
        for (int i = 0; i < 4; i++) begin
            start    = 1'($urandom);
            in_valid = 1'($urandom);
            k_len    = KW'($urandom);
            rand_ops();
            tick();
        end
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;

        // Single wavefront with known words
        start = 1'b1;
        k_len = 8'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        a_vec = {16'd4, 16'd3, 16'd2, 16'd1};
        b_vec = {16'd8, 16'd7, 16'd6, 16'd5};
        tick();
        in_valid = 1'b0;
        rand_ops();
        repeat (ROWS + COLS + 4) tick();

        // K=3 with a two-cycle bubble, checked through a behavioural PE array
        s = cyc;
        start = 1'b1;
        k_len = 8'd3;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < ROWS; r++) a_vec[r*WS +: WS] = WS'(r*3 + k + 1);
            for (int c = 0; c < COLS; c++) b_vec[c*WS +: WS] = WS'(k*4 + c + 1);
            in_valid = 1'b1;
            tick();
            if (k == 0) begin
                in_valid = 1'b0;
                rand_ops();
                repeat (2) tick();
            end
        end
        in_valid = 1'b0;
        repeat (ROWS + COLS + 6) tick();
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                sum = 0;
                for (int n = s; n < cyc; n++) begin
                    if (n - j >= s && n - i >= s) begin
                        lv = obs_l[n-j];
                        tv = obs_t[n-i];
                        sum += int'(lv[i*WS +: WS]) * int'(tv[j*WS +: WS]);
                    end
                end
                golden = 0;
                for (int k = 0; k < 3; k++) golden += (i*3 + k + 1) * (k*4 + j + 1);
                check($sformatf("c_%0d_%0d", i, j), 64'(sum), 64'(golden));
            end
        end

        // Zero-length job
        in_valid = 1'b1;
        rand_ops();
        start = 1'b1;
        k_len = 8'd0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        in_valid = 1'b0;

        // Start pulses during STREAM and on the done cycle are ignored
        start = 1'b1;
        k_len = 8'd4;
        tick();
        for (int i = 0; i < 200 && (in_job || done_at >= cyc); i++) begin
            start = (cyc == done_at) || ($urandom_range(3) == 0);
            k_len = (cyc == done_at) ? 8'd5 : KW'($urandom_range(1, 9));
            in_valid = ($urandom_range(99) < 60);
            rand_ops();
            tick();
        end
        check("restart_job_finished", 64'(in_job), 64'd0);
        start = 1'b0;
        in_valid = 1'b0;
        repeat (ROWS + COLS + 2) tick();

        // Asynchronous reset in the middle of DRAIN
        start = 1'b1;
        k_len = 8'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        rand_ops();
        tick();
        rand_ops();
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        in_job = 1'b0;
        done_at = -1;
        clear_cyc = cyc;
        check("async_rst_left", 64'(left_in_bus), 64'd0);
        check("async_rst_top", 64'(top_in_bus), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        repeat (ROWS + COLS + 4) tick();
        run_job(2, 100);

        // Randomised jobs
        for (int j = 0; j < 4; j++) begin
            run_job($urandom_range(1, 6), 70);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
